// File: rtl/switch_voq_islip_scheduler_if.sv
// switch_voq_islip_scheduler_if: VOQ request / match bundle; SWITCH_SCHED_STATS_EN adds counters
interface switch_voq_islip_scheduler_if #(
  parameter int RADIX = 4,
  parameter int SEL_WIDTH = (RADIX > 1) ? $clog2(RADIX) : 1
);
  logic enable;
  logic [RADIX*RADIX-1:0] voq_req;
  logic [RADIX-1:0] pkt_done;
  logic [RADIX*RADIX-1:0] grant;
  logic [RADIX*SEL_WIDTH-1:0] out_sel;
  logic [RADIX-1:0] out_sel_valid;
`ifdef SWITCH_SCHED_STATS_EN
  logic [31:0] match_count;
  logic [31:0] conflict_count;
  modport master (output enable, voq_req, pkt_done, input grant, out_sel, out_sel_valid, match_count, conflict_count);
  modport slave (input enable, voq_req, pkt_done, output grant, out_sel, out_sel_valid, match_count, conflict_count);
`else
  modport master (output enable, voq_req, pkt_done, input grant, out_sel, out_sel_valid);
  modport slave (input enable, voq_req, pkt_done, output grant, out_sel, out_sel_valid);
`endif
endinterface

// File: rtl/switch_voq_islip_scheduler.sv
// switch_voq_islip_scheduler: single-iteration iSLIP VOQ matcher with per-output locks; SWITCH_SCHED_STATS_EN adds counters
module switch_voq_islip_scheduler #(
  parameter int RADIX = 4,
  parameter int SEL_WIDTH = (RADIX > 1) ? $clog2(RADIX) : 1
) (
  input logic clk,
  input logic rst,
  switch_voq_islip_scheduler_if.slave bus
);
  logic [RADIX*RADIX-1:0] grant_q;
  logic [RADIX*SEL_WIDTH-1:0] sel_q;
  logic [RADIX-1:0] valid_q;
  logic [SEL_WIDTH-1:0] gptr [RADIX];
  logic [SEL_WIDTH-1:0] aptr [RADIX];
  logic [RADIX-1:0] busy;
  logic [RADIX-1:0] gnt [RADIX];
  logic [RADIX-1:0] acc [RADIX];
  assign bus.grant = grant_q;
  assign bus.out_sel = sel_q;
  assign bus.out_sel_valid = valid_q;
  // an input is busy while any output row holds it
  always_comb begin
    busy = '0;
    for (int o = 0; o < RADIX; o++) busy = busy | grant_q[o*RADIX +: RADIX];
  end
  // request/grant from gptr over free ports, then accept from aptr
  always_comb begin
    int k;
    logic f;
    for (int o = 0; o < RADIX; o++) begin
      gnt[o] = '0;
      acc[o] = '0;
    end
    for (int o = 0; o < RADIX; o++) begin
      f = 1'b0;
      for (int n = 0; n < RADIX; n++) begin
        k = int'(gptr[o]) + n;
        k = (k >= RADIX) ? k - RADIX : k;
        if (!f && bus.enable && !valid_q[o] && !busy[k] && bus.voq_req[o*RADIX+k]) begin
          f = 1'b1;
          gnt[o][k] = 1'b1;
        end
      end
    end
    for (int i = 0; i < RADIX; i++) begin
      f = 1'b0;
      for (int n = 0; n < RADIX; n++) begin
        k = int'(aptr[i]) + n;
        k = (k >= RADIX) ? k - RADIX : k;
        if (!f && gnt[k][i]) begin
          f = 1'b1;
          acc[k][i] = 1'b1;
        end
      end
    end
  end
  // release on pkt_done wins over matching; pointers move only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      sel_q <= '0;
      valid_q <= '0;
      for (int n = 0; n < RADIX; n++) begin
        gptr[n] <= '0;
        aptr[n] <= '0;
      end
    end else begin
      for (int o = 0; o < RADIX; o++) begin
        if (valid_q[o] && bus.pkt_done[o]) begin
          valid_q[o] <= 1'b0;
          grant_q[o*RADIX +: RADIX] <= '0;
        end else if (|acc[o]) begin
          valid_q[o] <= 1'b1;
          grant_q[o*RADIX +: RADIX] <= acc[o];
        end
        for (int i = 0; i < RADIX; i++) begin
          if (acc[o][i]) begin
            sel_q[o*SEL_WIDTH +: SEL_WIDTH] <= SEL_WIDTH'(i);
            gptr[o] <= (i == RADIX-1) ? '0 : SEL_WIDTH'(i+1);
            aptr[i] <= (o == RADIX-1) ? '0 : SEL_WIDTH'(o+1);
          end
        end
      end
    end
  end
`ifdef SWITCH_SCHED_STATS_EN
  logic [31:0] n_acc, n_gnt;
  logic [32:0] m_sum, c_sum;
  // per-cycle accepted pairs and grants that lost at the input
  always_comb begin
    n_acc = '0;
    n_gnt = '0;
    for (int o = 0; o < RADIX; o++) begin
      n_acc = n_acc + 32'($countones(acc[o]));
      n_gnt = n_gnt + 32'($countones(gnt[o]));
    end
    m_sum = {1'b0, bus.match_count} + {1'b0, n_acc};
    c_sum = {1'b0, bus.conflict_count} + {1'b0, n_gnt - n_acc};
  end
  // saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.match_count <= '0;
      bus.conflict_count <= '0;
    end else begin
      bus.match_count <= m_sum[32] ? '1 : m_sum[31:0];
      bus.conflict_count <= c_sum[32] ? '1 : c_sum[31:0];
    end
  end
`endif
endmodule

// File: doc/switch_voq_islip_scheduler.md
Name: switch_voq_islip_scheduler

Overview:
Single-iteration iSLIP scheduler for the input-queued VOQ crossbar. It takes the RADIX x RADIX VOQ request matrix and computes a conflict-free input/output matching using round-robin grant and accept pointers. It holds each matched pair until the packet completes at that output. The grant matrix gates the crossbar's per-VOQ tvalid/tready, so at most one input drives each output and each input feeds at most one output.

Parameters:
RADIX, 4, number of switch ports; 2..32, any integer (not restricted to powers of two).
SEL_WIDTH, (RADIX>1 ? $clog2(RADIX) : 1), width of the per-output selected-input index.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-high reset.
enable  input  1  1 = new matches allowed; 0 = existing locks held, no new matches.
voq_req  input  RADIX*RADIX  bit o*RADIX+i: input i has a packet queued for output o (same flat layout as the crossbar s_axis_* vectors).
pkt_done  input  RADIX  bit o: output o transferred its last beat this cycle (m_axis_tvalid & m_axis_tready & m_axis_tlast).
grant  output  RADIX*RADIX  registered match matrix, same layout as voq_req.
out_sel  output  RADIX*SEL_WIDTH  per-output matched input index.
out_sel_valid  output  RADIX  per-output lock active.

Behaviour:
- Reset (asynchronous, active-high): grant=0, out_sel=0, out_sel_valid=0, all grant pointers gptr[o]=0, all accept pointers aptr[i]=0. Reset asserted mid-packet drops every lock immediately.
- State per output o: FREE or LOCKED(i). Input i is busy if any output is LOCKED(i).
- Each cycle, combinational scheduling over free ports only:
  - Request: r[o][i] = voq_req[o*RADIX+i] & enable & output o FREE & input i not busy.
  - Grant: each free output picks the first requesting i, searching from gptr[o] upward with wrap RADIX-1 -> 0.
  - Accept: each input picks the first granting o, searching from aptr[i] upward with wrap.
- On the clock edge, each accepted pair (o,i):
  - output o becomes LOCKED(i); grant[o*RADIX+i]=1; out_sel[o]=i; out_sel_valid[o]=1.
  - gptr[o] = (i==RADIX-1) ? 0 : i+1; aptr[i] = (o==RADIX-1) ? 0 : o+1.
  - Pointers update only on accept; a grant that is not accepted leaves gptr unchanged (iSLIP desynchronisation rule).
- Latency:
  - Request at cycle t on free ports -> grant high at t+1.
  - pkt_done[o] at t on LOCKED output -> grant and out_sel_valid low at t+1, out_sel held at last value.
  - An output released at t is not FREE during cycle t, so its earliest re-grant is at t+2. Same for the released input.
- Lock is held regardless of voq_req; dropping the request mid-packet does not release the lock.
- pkt_done on a FREE output is ignored.
- Simultaneous release on output A and new request to output A in the same cycle: release wins; output A is matched no earlier than the next cycle.
- enable=0: no new locks and pointers frozen; pkt_done still releases.
- Invariant: every row and every column of grant has at most one set bit. RADIX=1 degenerates to lock/unlock of the single pair.

Optional Feature:
SWITCH_SCHED_STATS_EN
- Defined:
  - Adds output port match_count (32 bits, reset 0), incremented by the number of pairs accepted each cycle, saturating at 2^32-1.
  - Adds output port conflict_count (32 bits, reset 0), incremented by the number of grants not accepted each cycle, saturating.
- Undefined: neither port nor its counters exist; scheduling behaviour is identical.

Test Plan:
- Reset, RADIX=4, voq_req bits 0 (o0,i0) and 5 (o1,i1) set at t0 -> grant=0x0021 at t1; gptr[0]=1, gptr[1]=2, aptr[0]=1, aptr[1]=2.
- Inputs 0..3 all request output 2 only, pointers 0 -> grant bit 8 (i0); pkt_done[2] -> grant bit 9 (i1) two cycles later; round-robin continues i2, i3, i0.
- Input 0 requests outputs 0..3 and all outputs grant it -> only o0 is accepted; gptr[1..3] unchanged; with SWITCH_SCHED_STATS_EN, conflict_count=3 and match_count=1.
- Lock (o3,i2), then drop voq_req for 10 cycles without pkt_done -> grant bit 14 held; pkt_done[3] -> cleared next cycle.
- Full 4x4 request matrix for 1000 cycles, random pkt_done -> per-cycle row/column one-hot check passes; each input's long-run grant share differs by less than 2%.
- Assert rst with 4 locks active -> grant=0 and out_sel_valid=0 immediately; with stats enabled, counters=0; first post-reset match is from pointers at 0.
